// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer: register word offsets, CTRL bit
// positions, APB FSM encoding, wait-state counter width and a byte-lane
// merge helper.
package apb_timer_pkg;

  // Register offsets as word indices (PADDR[4:2])
  localparam logic [2:0] OFS_CTRL     = 3'd0;  // 0x00
  localparam logic [2:0] OFS_LOAD     = 3'd1;  // 0x04
  localparam logic [2:0] OFS_COUNT    = 3'd2;  // 0x08
  localparam logic [2:0] OFS_PRESCALE = 3'd3;  // 0x0C
  localparam logic [2:0] OFS_STATUS   = 3'd4;  // 0x10

  // CTRL bit indices
  localparam int CTRL_EN    = 0;
  localparam int CTRL_MODE  = 1;
  localparam int CTRL_IRQEN = 2;

  // APB access FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } apb_state_t;

  // Wait-state counter width (WAIT_STATES is 0..15)
  localparam int WCNT_W = 4;

  // Replace only the byte lanes whose strobe is set
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_timer_if.sv
// APB bus bundle between the master and the timer slave.
// Latency/backpressure: none of its own; PREADY from the slave stalls the master.
// Ports: PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB from master; PRDATA/PREADY/PSLVERR from slave.
interface apb_timer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [3:0]            PSTRB;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_timer_core.sv
// Prescaled 32-bit down-counter with one-shot/periodic reload and expiry pulse.
// Latency: count and prescaler update on the clock edge; expire_pulse is combinational on the expiring tick.
// Backpressure: none; start_pulse has priority over counting, en=0 freezes all state.
// Ports: clk, rst_n (sync), en, mode, load, prescale, start_pulse in; count, expire_pulse out.
module apb_timer_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        mode,
  input  logic [31:0] load,
  input  logic [15:0] prescale,
  input  logic        start_pulse,
  output logic [31:0] count,
  output logic        expire_pulse
);

  logic [15:0] pre;
  logic        tick;

  // >= rather than == so shrinking PRESCALE mid-run cannot strand the prescaler
  assign tick         = en && (pre >= prescale);
  assign expire_pulse = tick && (count == 32'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 32'd0;
      pre   <= 16'd0;
    end else if (start_pulse) begin
      count <= load;
      pre   <= 16'd0;
    end else if (en) begin
      if (tick) begin
        pre <= 16'd0;
        if (count != 32'd0) begin
          count <= count - 32'd1;
        end else if (mode) begin
          count <= load;
        end
      end else begin
        pre <= pre + 16'd1;
      end
    end
  end

endmodule

// File: rtl/apb_timer_slave.sv
// APB timer slave: access FSM with WAIT_STATES stall cycles, register file and timer core.
// Latency: setup at T gives PREADY at T+1+WAIT_STATES; write commits on that PREADY edge.
// Backpressure: PREADY held low for WAIT_STATES cycles; PSEL dropping mid-wait abandons the access.
// Ports: PCLK, PRESETn (sync, active-low), apb (slave modport), timer_irq (registered).
module apb_timer_slave
  import apb_timer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  apb_timer_if.slave  apb,
  output logic        timer_irq
);

  localparam logic [WCNT_W-1:0] WS_INIT  = WCNT_W'(WAIT_STATES);
  localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

  apb_state_t            state;
  logic [WCNT_W-1:0]     wcnt;
  logic                  ctrl_en;
  logic                  ctrl_mode;
  logic                  ctrl_irqen;
  logic [DATA_WIDTH-1:0] load_q;
  logic [15:0]           prescale_q;
  logic                  expired;
  logic [31:0]           count;
  logic                  expire_pulse;

  logic [2:0]            idx;
  logic                  resp;
  logic                  err;
  logic                  wr;
  logic                  start_pulse;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  unused_addr;

  assign idx  = apb.PADDR[4:2];
  assign resp = (state == ST_RESP);
  assign err  = (idx > OFS_STATUS) || (apb.PWRITE && idx == OFS_COUNT);
  assign wr   = resp && apb.PSEL && apb.PENABLE && apb.PWRITE && !err;

  // Only a 0->1 transition of EN restarts the count from LOAD
  assign start_pulse = wr && idx == OFS_CTRL && apb.PSTRB[0] &&
                       apb.PWDATA[CTRL_EN] && !ctrl_en;

  assign unused_addr = ^{apb.PADDR[ADDR_WIDTH-1:5], apb.PADDR[1:0]};

  always_comb begin
    rd_mux = '0;
    case (idx)
      OFS_CTRL:     rd_mux = {{(DATA_WIDTH-3){1'b0}}, ctrl_irqen, ctrl_mode, ctrl_en};
      OFS_LOAD:     rd_mux = load_q;
      OFS_COUNT:    rd_mux = count;
      OFS_PRESCALE: rd_mux = {{(DATA_WIDTH-16){1'b0}}, prescale_q};
      OFS_STATUS:   rd_mux = {{(DATA_WIDTH-1){1'b0}}, expired};
      default:      rd_mux = '0;
    endcase
  end

  assign apb.PREADY  = resp;
  assign apb.PSLVERR = resp && err;
  assign apb.PRDATA  = (resp && !err) ? rd_mux : '0;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state      <= ST_IDLE;
      wcnt       <= '0;
      ctrl_en    <= 1'b0;
      ctrl_mode  <= 1'b0;
      ctrl_irqen <= 1'b0;
      load_q     <= '0;
      prescale_q <= '0;
      expired    <= 1'b0;
      timer_irq  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (apb.PSEL && !apb.PENABLE) begin
            wcnt  <= WS_INIT;
            state <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!apb.PSEL) begin
            state <= ST_IDLE;
          end else begin
            wcnt <= wcnt - WCNT_ONE;
            if (wcnt == WCNT_ONE) state <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (wr && idx == OFS_CTRL && apb.PSTRB[0]) begin
        ctrl_en    <= apb.PWDATA[CTRL_EN];
        ctrl_mode  <= apb.PWDATA[CTRL_MODE];
        ctrl_irqen <= apb.PWDATA[CTRL_IRQEN];
      end
      // One-shot expiry stops the timer even if a CTRL write lands on the same edge
      if (expire_pulse && !ctrl_mode) ctrl_en <= 1'b0;

      if (wr && idx == OFS_LOAD) load_q <= strb_merge(load_q, apb.PWDATA, apb.PSTRB);

      if (wr && idx == OFS_PRESCALE) begin
        if (apb.PSTRB[0]) prescale_q[7:0]  <= apb.PWDATA[7:0];
        if (apb.PSTRB[1]) prescale_q[15:8] <= apb.PWDATA[15:8];
      end

      // Expiry beats a simultaneous W1C so no event is lost
      if (expire_pulse) begin
        expired <= 1'b1;
      end else if (wr && idx == OFS_STATUS && apb.PSTRB[0] && apb.PWDATA[0]) begin
        expired <= 1'b0;
      end

      timer_irq <= expired && ctrl_irqen;
    end
  end

  apb_timer_core u_core (
    .clk          (PCLK),
    .rst_n        (PRESETn),
    .en           (ctrl_en),
    .mode         (ctrl_mode),
    .load         (load_q),
    .prescale     (prescale_q),
    .start_pulse  (start_pulse),
    .count        (count),
    .expire_pulse (expire_pulse)
  );

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave with WAIT_STATES=2: register-access vector
// table plus hand-written timer, W1C race and mid-access reset sequences.
module tb_apb_timer_slave;

  logic PCLK;
  logic PRESETn;
  logic timer_irq;
  int   n_cmp;
  int   n_mis;

  apb_timer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_timer_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(2)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .apb       (bus),
    .timer_irq (timer_irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just after a clock edge; returns just after the commit edge.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic err, output int lat);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = wdata;
    bus.PSTRB   = strb;
    lat = 0;
    do begin
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1;
      lat++;
    end while (!bus.PREADY && lat < 20);
    rdata = bus.PRDATA;
    err   = bus.PSLVERR;
    @(posedge PCLK); #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic do_write(input string name, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] rd;
    logic        er;
    int          lt;
    apb_xfer(1'b1, addr, wdata, strb, rd, er, lt);
    check({name, " err"}, {31'd0, er}, 32'd0);
    check({name, " lat"}, lt, 32'd3);
  endtask

  task automatic do_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    int          lt;
    apb_xfer(1'b0, addr, 32'd0, 4'h0, rd, er, lt);
    check({name, " err"}, {31'd0, er}, 32'd0);
    check({name, " data"}, rd, exp);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lt;
    logic [31:0] per_cnt [9];

    n_cmp = 0;
    n_mis = 0;
    per_cnt = '{32'd3, 32'd3, 32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0, 32'd3};

    //            wr    addr        wdata         strb     exp_rd        exp_err
    vecs[0]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h0C, 32'h0,        4'h0, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h10, 32'h0,        4'h0, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'h14, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 32'h04, 32'h12345678, 4'h5, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'h00340078, 1'b0};
    vecs[8]  = '{1'b1, 32'h0C, 32'hABCD1234, 4'hF, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h0C, 32'h0,        4'h0, 32'h00001234, 1'b0};
    vecs[10] = '{1'b1, 32'h0C, 32'h0000FF00, 4'h2, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'h0C, 32'h0,        4'h0, 32'h0000FF34, 1'b0};
    vecs[12] = '{1'b1, 32'h00, 32'hFFFFFFF6, 4'hF, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h00000006, 1'b0};
    vecs[14] = '{1'b1, 32'h00, 32'h0,        4'h1, 32'h0,        1'b0};
    vecs[15] = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h0,        1'b0};
    vecs[16] = '{1'b1, 32'h18, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[17] = '{1'b0, 32'h24, 32'h0,        4'h0, 32'h00340078, 1'b0};

    PRESETn     = 1'b0;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
    bus.PSTRB   = '0;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst PREADY",    {31'd0, bus.PREADY},  32'd0);
    check("rst PSLVERR",   {31'd0, bus.PSLVERR}, 32'd0);
    check("rst PRDATA",    bus.PRDATA,           32'd0);
    check("rst timer_irq", {31'd0, timer_irq},   32'd0);
    PRESETn = 1'b1;

    // Register access table; every access (back-to-back) must take 3 cycles
    for (int i = 0; i < 18; i++) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, lt);
      check($sformatf("vec%0d err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d lat", i), lt, 32'd3);
      if (!vecs[i].wr) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
    end

    // Periodic: LOAD=3, PRESCALE=1 -> 8-cycle period
    do_write("load3", 32'h04, 32'd3, 4'hF);
    do_write("pre1",  32'h0C, 32'd1, 4'hF);
    do_write("ctrl7", 32'h00, 32'd7, 4'h1);
    // now just after start edge E0
    for (int i = 0; i < 9; i++) begin
      check($sformatf("per count%0d", i), dut.count, per_cnt[i]);
      check($sformatf("per expired%0d", i), {31'd0, dut.expired}, (i == 8) ? 32'd1 : 32'd0);
      check($sformatf("per irq%0d", i), {31'd0, timer_irq}, 32'd0);
      @(posedge PCLK); #1;
    end
    check("per irq rise", {31'd0, timer_irq}, 32'd1);

    // W1C committing on the E16 expiry edge: set wins
    repeat (3) begin @(posedge PCLK); #1; end
    do_write("w1c race", 32'h10, 32'd1, 4'h1);
    check("race expired", {31'd0, dut.expired}, 32'd1);
    do_write("w1c clear", 32'h10, 32'd1, 4'h1);
    check("clr expired", {31'd0, dut.expired}, 32'd0);
    check("clr irq same", {31'd0, timer_irq}, 32'd1);
    @(posedge PCLK); #1;
    check("clr irq drop", {31'd0, timer_irq}, 32'd0);

    // Stop at E25 (count reloaded to 3 at E24, no tick at E25) -> frozen
    do_write("stop", 32'h00, 32'd0, 4'h1);
    check("stop count", dut.count, 32'd3);
    repeat (5) begin @(posedge PCLK); #1; end
    check("frozen count", dut.count, 32'd3);
    do_write("w1c post", 32'h10, 32'd1, 4'h1);
    check("post expired", {31'd0, dut.expired}, 32'd0);

    // One-shot: LOAD=2, PRESCALE=0
    do_write("load2", 32'h04, 32'd2, 4'hF);
    do_write("pre0",  32'h0C, 32'd0, 4'hF);
    do_write("ctrl1", 32'h00, 32'd1, 4'h1);
    check("os count0", dut.count, 32'd2);
    @(posedge PCLK); #1;
    check("os count1", dut.count, 32'd1);
    @(posedge PCLK); #1;
    check("os count2", dut.count, 32'd0);
    check("os exp2", {31'd0, dut.expired}, 32'd0);
    @(posedge PCLK); #1;
    check("os exp3", {31'd0, dut.expired}, 32'd1);
    repeat (3) begin @(posedge PCLK); #1; end
    do_read("os ctrl",   32'h00, 32'd0);
    do_read("os count",  32'h08, 32'd0);
    do_read("os status", 32'h10, 32'd1);

    // Write to COUNT is refused
    apb_xfer(1'b1, 32'h08, 32'h55, 4'hF, rd, er, lt);
    check("cnt wr err", {31'd0, er}, 32'd1);
    do_read("cnt after wr", 32'h08, 32'd0);

    // Reset while in ST_WAIT abandons the access
    do_write("load pre-rst", 32'h04, 32'hCAFE0001, 4'hF);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = 32'h04;
    bus.PWDATA  = 32'hDEADBEEF;
    bus.PSTRB   = 4'hF;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    PRESETn     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge PCLK); #1;
      check($sformatf("rst wait ready%0d", i), {31'd0, bus.PREADY}, 32'd0);
    end
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    PRESETn     = 1'b1;
    @(posedge PCLK); #1;
    do_read("rr ctrl",     32'h00, 32'd0);
    do_read("rr load",     32'h04, 32'd0);
    do_read("rr count",    32'h08, 32'd0);
    do_read("rr prescale", 32'h0C, 32'd0);
    do_read("rr status",   32'h10, 32'd0);
    check("rr irq", {31'd0, timer_irq}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
